// File: rtl/dot_pkg.sv
// Shared encodings for the dot-matrix animation sequencer and its renderer.
package dot_pkg;

    localparam logic [1:0] FRAME_TURN   = 2'd0;
    localparam logic [1:0] FRAME_WINNER = 2'd1;
    localparam logic [1:0] FRAME_BANNER = 2'd2;
    localparam logic [1:0] FRAME_BLANK  = 2'd3;

    localparam logic [1:0] GAME_PLAY = 2'b00;
    localparam logic [1:0] GAME_OWIN = 2'b01;
    localparam logic [1:0] GAME_XWIN = 2'b10;
    localparam logic [1:0] GAME_BAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_TURN,
        ST_HOLD,
        ST_SCROLL,
        ST_ERR
    } dot_state_t;

endpackage

// File: rtl/dot_anim_sequencer_if.sv
// Game-state inputs and renderer controls exchanged with the animation sequencer.
interface dot_anim_sequencer_if #(
    parameter int unsigned OFS_W = 6
);
    logic             whosTurn;
    logic [1:0]       gameend;
    logic             freeze;
    logic [1:0]       frame_sel;
    logic             winner;
    logic             turn_x;
    logic             blank;
    logic [OFS_W-1:0] scroll_ofs;
    logic             loop_done;

    modport master (
        output whosTurn, gameend, freeze,
        input  frame_sel, winner, turn_x, blank, scroll_ofs, loop_done
    );

    modport slave (
        input  whosTurn, gameend, freeze,
        output frame_sel, winner, turn_x, blank, scroll_ofs, loop_done
    );
endinterface

// File: rtl/dot_blink_gen.sv
// On/off duty counter: dark_nxt is the blink level after the coming edge,
// so callers can register it alongside their other outputs.
module dot_blink_gen #(
    parameter int unsigned ON_TICKS  = 1,
    parameter int unsigned OFF_TICKS = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic dark_nxt
);
    localparam int unsigned PERIOD = ON_TICKS + OFF_TICKS;
    localparam int unsigned CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
    localparam logic [CW-1:0] ON_V = CW'(ON_TICKS);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
        dark_nxt = (cnt_d >= ON_V);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/dot_anim_sequencer.sv
// 2 Hz sequencer choosing turn/winner/banner frames, blink and banner scroll
// offset for the dot-matrix renderer.
module dot_anim_sequencer
    import dot_pkg::*;
#(
    parameter int unsigned NUM_PANELS = 2,
    parameter int unsigned MSG_COLS   = 32,
    parameter int unsigned BLINK_ON   = 1,
    parameter int unsigned BLINK_OFF  = 1,
    parameter int unsigned HOLD_TICKS = 4
) (
    input  logic                 clk_2Hz,
    input  logic                 reset,
    dot_anim_sequencer_if.slave  bus
);
    localparam int unsigned OFS_W      = $clog2(MSG_COLS + 1);
    localparam int unsigned SCROLL_MAX = MSG_COLS - 8 * NUM_PANELS;
    localparam int unsigned HOLD_W     = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [OFS_W-1:0]  SCROLL_MAX_V = OFS_W'(SCROLL_MAX);
    localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(HOLD_TICKS - 1);

    if (MSG_COLS < 8 * NUM_PANELS) begin : g_bad_cols
        $error("dot_anim_sequencer: MSG_COLS must be >= 8*NUM_PANELS");
    end
    if (BLINK_ON < 1 || BLINK_OFF < 1 || HOLD_TICKS < 1) begin : g_bad_ticks
        $error("dot_anim_sequencer: BLINK_ON, BLINK_OFF and HOLD_TICKS must be >= 1");
    end

    dot_state_t        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [OFS_W-1:0]  ofs_q, ofs_d;
    logic              winner_q, winner_d;
    logic              turn_x_q, turn_x_d;
    logic              blank_q, blank_d;
    logic              loop_done_q, loop_done_d;
    logic [1:0]        frame_q, frame_d;
    logic              hold_start;
    logic              blink_clr, blink_en, blink_dark;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        ofs_d       = ofs_q;
        winner_d    = winner_q;
        turn_x_d    = turn_x_q;
        loop_done_d = 1'b0;
        hold_start  = 1'b0;
        if (!bus.freeze) begin
            case (bus.gameend)
                GAME_BAD:  state_d = ST_ERR;
                GAME_PLAY: state_d = ST_TURN;
                default: begin
                    if (state_q == ST_TURN || state_q == ST_ERR || bus.gameend[1] != winner_q) begin
                        hold_start = 1'b1;
                    end else if (state_q == ST_HOLD) begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = ST_SCROLL;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end else if (ofs_q == SCROLL_MAX_V) begin
                        hold_start = 1'b1;
                    end else begin
                        ofs_d = ofs_q + 1'b1;
                    end
                end
            endcase
            if (hold_start) begin
                state_d  = ST_HOLD;
                winner_d = bus.gameend[1];
                hold_d   = '0;
            end
            // Counters only live in their own phase; clearing them here
            // covers every exit path at once.
            if (state_d != ST_SCROLL || state_q != ST_SCROLL) ofs_d = '0;
            if (state_d != ST_HOLD) hold_d = '0;
            if (state_d == ST_TURN) turn_x_d = bus.whosTurn;
            loop_done_d = (state_d == ST_SCROLL) && (ofs_d == SCROLL_MAX_V);
        end
    end

    assign blink_clr = !bus.freeze && (state_d != ST_HOLD || hold_start);
    assign blink_en  = !bus.freeze && (state_d == ST_HOLD) && !hold_start;

    dot_blink_gen #(
        .ON_TICKS  (BLINK_ON),
        .OFF_TICKS (BLINK_OFF)
    ) u_blink (
        .clk      (clk_2Hz),
        .reset    (reset),
        .clr      (blink_clr),
        .en       (blink_en),
        .dark_nxt (blink_dark)
    );

    always_comb begin
        frame_d = FRAME_TURN;
        blank_d = 1'b0;
        case (state_d)
            ST_TURN:   frame_d = FRAME_TURN;
            ST_HOLD:   begin frame_d = FRAME_WINNER; blank_d = blink_dark; end
            ST_SCROLL: frame_d = FRAME_BANNER;
            ST_ERR:    begin frame_d = FRAME_BLANK; blank_d = 1'b1; end
            default:   frame_d = FRAME_TURN;
        endcase
    end

    always_ff @(posedge clk_2Hz or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_TURN;
            hold_q      <= '0;
            ofs_q       <= '0;
            winner_q    <= 1'b0;
            turn_x_q    <= 1'b0;
            blank_q     <= 1'b0;
            loop_done_q <= 1'b0;
            frame_q     <= FRAME_TURN;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            ofs_q       <= ofs_d;
            winner_q    <= winner_d;
            turn_x_q    <= turn_x_d;
            blank_q     <= blank_d;
            loop_done_q <= loop_done_d;
            frame_q     <= frame_d;
        end
    end

    assign bus.frame_sel  = frame_q;
    assign bus.winner     = winner_q;
    assign bus.turn_x     = turn_x_q;
    assign bus.blank      = blank_q;
    assign bus.scroll_ofs = ofs_q;
    assign bus.loop_done  = loop_done_q;
endmodule

// File: tb/tb_dot_anim_sequencer.sv
// Directed bench: two-panel sequencer through turn/hold/scroll/freeze/error
// and reset, plus a four-panel instance with a zero-length scroll.
module tb_dot_anim_sequencer;
    logic clk_2Hz = 1'b0;
    logic reset   = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk_2Hz = ~clk_2Hz;

    dot_anim_sequencer_if #(.OFS_W(6)) bus_a ();
    dot_anim_sequencer_if #(.OFS_W(6)) bus_b ();

    dot_anim_sequencer #(
        .NUM_PANELS (2),
        .MSG_COLS   (32),
        .BLINK_ON   (1),
        .BLINK_OFF  (1),
        .HOLD_TICKS (4)
    ) dut_a (
        .clk_2Hz (clk_2Hz),
        .reset   (reset),
        .bus     (bus_a)
    );

    dot_anim_sequencer #(
        .NUM_PANELS (4),
        .MSG_COLS   (32),
        .BLINK_ON   (1),
        .BLINK_OFF  (1),
        .HOLD_TICKS (4)
    ) dut_b (
        .clk_2Hz (clk_2Hz),
        .reset   (reset),
        .bus     (bus_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_2Hz);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_a.whosTurn = 1'b0; bus_a.gameend = 2'b00; bus_a.freeze = 1'b0;
        bus_b.whosTurn = 1'b0; bus_b.gameend = 2'b00; bus_b.freeze = 1'b0;
        tick(); tick();

        chk("rst frame_sel",  8'(bus_a.frame_sel), 8'd0);
        chk("rst winner",     8'(bus_a.winner), 8'd0);
        chk("rst turn_x",     8'(bus_a.turn_x), 8'd0);
        chk("rst blank",      8'(bus_a.blank), 8'd0);
        chk("rst scroll_ofs", 8'(bus_a.scroll_ofs), 8'd0);
        chk("rst loop_done",  8'(bus_a.loop_done), 8'd0);

        // Turn display follows whosTurn one tick later
        reset = 1'b1;
        tick();
        chk("turn0 turn_x", 8'(bus_a.turn_x), 8'd0);
        chk("turn0 frame",  8'(bus_a.frame_sel), 8'd0);
        bus_a.whosTurn = 1'b1;
        chk("turn1 pre turn_x", 8'(bus_a.turn_x), 8'd0);
        tick();
        chk("turn1 turn_x", 8'(bus_a.turn_x), 8'd1);
        chk("turn1 frame",  8'(bus_a.frame_sel), 8'd0);
        chk("turn1 blank",  8'(bus_a.blank), 8'd0);

        // O wins: hold with blink 0,1,0,1 then scroll 0..16
        bus_a.gameend = 2'b01;
        for (int unsigned i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("hold%0d frame", i), 8'(bus_a.frame_sel), 8'd1);
            chk($sformatf("hold%0d blank", i), 8'(bus_a.blank), 8'(i % 2));
            chk($sformatf("hold%0d winner", i), 8'(bus_a.winner), 8'd0);
        end
        for (int unsigned i = 0; i <= 16; i++) begin
            tick();
            chk($sformatf("scroll%0d frame", i), 8'(bus_a.frame_sel), 8'd2);
            chk($sformatf("scroll%0d ofs", i), 8'(bus_a.scroll_ofs), 8'(i));
            chk($sformatf("scroll%0d blank", i), 8'(bus_a.blank), 8'd0);
            chk($sformatf("scroll%0d loop_done", i), 8'(bus_a.loop_done), (i == 16) ? 8'd1 : 8'd0);
        end
        tick();
        chk("rehold frame",     8'(bus_a.frame_sel), 8'd1);
        chk("rehold ofs",       8'(bus_a.scroll_ofs), 8'd0);
        chk("rehold loop_done", 8'(bus_a.loop_done), 8'd0);
        chk("rehold blank",     8'(bus_a.blank), 8'd0);

        // Winner switched mid-scroll at ofs 5
        for (int unsigned i = 0; i < 9; i++) tick();
        chk("sw pre ofs",   8'(bus_a.scroll_ofs), 8'd5);
        chk("sw pre frame", 8'(bus_a.frame_sel), 8'd2);
        bus_a.gameend = 2'b10;
        tick();
        chk("sw frame",     8'(bus_a.frame_sel), 8'd1);
        chk("sw winner",    8'(bus_a.winner), 8'd1);
        chk("sw ofs",       8'(bus_a.scroll_ofs), 8'd0);
        chk("sw loop_done", 8'(bus_a.loop_done), 8'd0);
        chk("sw blank",     8'(bus_a.blank), 8'd0);

        // Freeze at ofs 7; gameend -> 00 is ignored until release
        for (int unsigned i = 0; i < 11; i++) tick();
        chk("frz pre ofs", 8'(bus_a.scroll_ofs), 8'd7);
        bus_a.freeze  = 1'b1;
        bus_a.gameend = 2'b00;
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("frz%0d ofs", i), 8'(bus_a.scroll_ofs), 8'd7);
            chk($sformatf("frz%0d frame", i), 8'(bus_a.frame_sel), 8'd2);
            chk($sformatf("frz%0d loop_done", i), 8'(bus_a.loop_done), 8'd0);
            chk($sformatf("frz%0d winner", i), 8'(bus_a.winner), 8'd1);
        end
        bus_a.freeze = 1'b0;
        tick();
        chk("unfrz frame",  8'(bus_a.frame_sel), 8'd0);
        chk("unfrz ofs",    8'(bus_a.scroll_ofs), 8'd0);
        chk("unfrz turn_x", 8'(bus_a.turn_x), 8'd1);

        // Invalid gameend, recovery to hold
        bus_a.gameend = 2'b11;
        tick();
        chk("err frame", 8'(bus_a.frame_sel), 8'd3);
        chk("err blank", 8'(bus_a.blank), 8'd1);
        tick();
        chk("err stay frame", 8'(bus_a.frame_sel), 8'd3);
        bus_a.gameend = 2'b01;
        tick();
        chk("err exit frame",  8'(bus_a.frame_sel), 8'd1);
        chk("err exit winner", 8'(bus_a.winner), 8'd0);
        chk("err exit blank",  8'(bus_a.blank), 8'd0);

        // Asynchronous reset mid-scroll, checked before the next rising edge
        for (int unsigned i = 0; i < 7; i++) tick();
        chk("ar pre ofs",   8'(bus_a.scroll_ofs), 8'd3);
        chk("ar pre frame", 8'(bus_a.frame_sel), 8'd2);
        #2 reset = 1'b0;
        #1;
        chk("ar frame",     8'(bus_a.frame_sel), 8'd0);
        chk("ar ofs",       8'(bus_a.scroll_ofs), 8'd0);
        chk("ar loop_done", 8'(bus_a.loop_done), 8'd0);
        chk("ar winner",    8'(bus_a.winner), 8'd0);
        chk("ar turn_x",    8'(bus_a.turn_x), 8'd0);
        chk("ar blank",     8'(bus_a.blank), 8'd0);
        tick();
        chk("ar hold loop_done", 8'(bus_a.loop_done), 8'd0);
        chk("ar hold frame",     8'(bus_a.frame_sel), 8'd0);

        // Four panels over 32 columns: single-tick scroll
        reset = 1'b1;
        bus_b.gameend = 2'b10;
        for (int unsigned i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("b hold%0d frame", i), 8'(bus_b.frame_sel), 8'd1);
            chk($sformatf("b hold%0d winner", i), 8'(bus_b.winner), 8'd1);
        end
        tick();
        chk("b scroll frame",     8'(bus_b.frame_sel), 8'd2);
        chk("b scroll ofs",       8'(bus_b.scroll_ofs), 8'd0);
        chk("b scroll loop_done", 8'(bus_b.loop_done), 8'd1);
        chk("b scroll winner",    8'(bus_b.winner), 8'd1);
        tick();
        chk("b rehold frame",     8'(bus_b.frame_sel), 8'd1);
        chk("b rehold loop_done", 8'(bus_b.loop_done), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
